// File: rtl/ins_assembler.sv
// ============================================================================
// ins_assembler: collects an opcode byte plus its operand bytes into one word
// Revision: 1.0
// ============================================================================
`default_nettype none

module ins_assembler #(
  parameter int DW   = 8,
  parameter int OPW  = 3,
  parameter int MAXB = 3,
  parameter logic [2*(2**OPW)-1:0] LEN_TABLE = '0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       flush,
  input  logic [DW-1:0]                              data_i,
  input  logic                                       data_vld_i,
  output logic                                       data_rdy_o,
  output logic [OPW-1:0]                             ins_o,
  output logic [DW-OPW-1:0]                          ad1_o,
  output logic [((MAXB > 1) ? DW*(MAXB-1) : 1)-1:0]  ad2_o,
  output logic [1:0]                                 len_o,
  output logic                                       ins_vld_o,
  input  logic                                       ins_rdy_i,
  output logic                                       err_o
);

  localparam int AW2 = (MAXB > 1) ? DW*(MAXB-1) : 1;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_opnd = 2'd1;
  localparam logic [1:0] c_hold = 2'd2;

  localparam logic [2:0] c_max_opnd = 3'(MAXB - 1);

  logic [1:0]        r_state;
  logic [2:0]        r_k;
  logic [OPW-1:0]    r_op;
  logic [DW-OPW-1:0] r_ad1;
  logic [AW2-1:0]    r_ad2;
  logic [1:0]        r_len;
  logic              r_err;

  logic [OPW-1:0]    w_op;
  logic [1:0]        w_n;
  logic              w_bad;
  logic              w_load0;

  assign w_op  = data_i[DW-1 -: OPW];
  assign w_n   = LEN_TABLE[{w_op, 1'b0} +: 2];
  assign w_bad = ({1'b0, w_n} > c_max_opnd);

  // A new byte0 is taken from IDLE, or from HOLD when the held word is consumed.
  assign w_load0 = !flush && data_vld_i &&
                   ((r_state == c_idle) || ((r_state == c_hold) && ins_rdy_i));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_idle;
      r_k     <= 3'd0;
      r_op    <= '0;
      r_ad1   <= '0;
      r_ad2   <= '0;
      r_len   <= 2'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (flush) begin
        r_state <= c_idle;
        r_k     <= 3'd0;
        r_op    <= '0;
        r_ad1   <= '0;
        r_ad2   <= '0;
        r_len   <= 2'd0;
      end else if (w_load0) begin
        r_op  <= w_op;
        r_ad1 <= data_i[DW-OPW-1:0];
        r_ad2 <= '0;
        if (w_bad) begin
          r_len   <= 2'd0;
          r_err   <= 1'b1;
          r_k     <= 3'd0;
          r_state <= c_hold;
        end else if (w_n == 2'd0) begin
          r_len   <= 2'd0;
          r_k     <= 3'd0;
          r_state <= c_hold;
        end else begin
          r_len   <= w_n;
          r_k     <= 3'd1;
          r_state <= c_opnd;
        end
      end else if ((r_state == c_opnd) && data_vld_i) begin
        for (int i = 0; i < MAXB - 1; i++) begin
          if (r_k == 3'(i + 1)) r_ad2[DW*i +: DW] <= data_i;
        end
        r_k <= r_k + 3'd1;
        if (r_k == {1'b0, r_len}) r_state <= c_hold;
      end else if ((r_state == c_hold) && ins_rdy_i) begin
        r_state <= c_idle;
      end else if (r_state == 2'd3) begin
        r_state <= c_idle;
      end
    end
  end

  assign data_rdy_o = (r_state != c_hold) || ins_rdy_i;
  assign ins_vld_o  = (r_state == c_hold);
  assign ins_o      = r_op;
  assign ad1_o      = r_ad1;
  assign ad2_o      = r_ad2;
  assign len_o      = r_len;
  assign err_o      = r_err;

endmodule

`default_nettype wire

// File: doc/ins_assembler.md
INS_ASSEMBLER -- requirements
Module: ins_assembler

Interface
REQ-001 Parameter: DW, default 8, width of the data bus byte and the first instruction byte.
REQ-002 Parameter: OPW, default 3, number of opcode bits, taken from the MSBs of the first byte.
REQ-003 Parameter: MAXB, default 3, maximum instruction length in bytes; legal range 1..4.
REQ-004 Parameter: LEN_TABLE, width 2*2**OPW, default all-zero; entry LEN_TABLE[2*op +: 2] is the operand-byte count for opcode op.
REQ-005 Port: clk, input, 1, clock; all state is updated on the rising edge.
REQ-006 Port: rst, input, 1, reset; asynchronous, active-low.
REQ-007 Port: flush, input, 1, synchronous abort of the instruction in progress.
REQ-008 Port: data_i, input, DW, byte from the program-memory bus.
REQ-009 Port: data_vld_i, input, 1, data_i is valid.
REQ-010 Port: data_rdy_o, output, 1, block accepts data_i this cycle.
REQ-011 Port: ins_o, output, OPW, opcode = byte0[DW-1 -: OPW].
REQ-012 Port: ad1_o, output, DW-OPW, register address = byte0[DW-OPW-1:0].
REQ-013 Port: ad2_o, output, DW*(MAXB-1) (min 1), packed operand bytes.
REQ-014 Port: len_o, output, 2, operand-byte count of the held instruction.
REQ-015 Port: ins_vld_o, output, 1, a complete instruction is held on ins_o/ad1_o/ad2_o/len_o.
REQ-016 Port: ins_rdy_i, input, 1, consumer takes the held instruction.
REQ-017 Port: err_o, output, 1, one-cycle pulse flagging an illegal length entry.

Function
REQ-018 A byte is transferred when data_vld_i and data_rdy_o are both high on a rising edge; an instruction is consumed when ins_vld_o and ins_rdy_i are both high.
REQ-019 The FSM has three states: IDLE (awaiting byte0), OPND (collecting operands), HOLD (instruction complete).
REQ-020 data_rdy_o = 1 in IDLE and OPND; in HOLD, data_rdy_o = ins_rdy_i, so back-to-back instructions are allowed.
REQ-021 On byte0 transfer, the block:
  - captures the opcode and address;
  - zeroes all of ad2_o;
  - sets len_o = n = LEN_TABLE entry;
  - goes to HOLD if n = 0, else to OPND with operand counter k = 1.
REQ-022 If n > MAXB-1, the block pulses err_o for one cycle, forces len_o = 0, and goes to HOLD.
REQ-023 On an operand transfer in OPND, the block stores data_i into ad2_o[DW*(k-1) +: DW] and increments k; the transfer with k = n moves the FSM to HOLD.
REQ-024 ins_vld_o = 1 exactly in HOLD; ins_o, ad1_o, ad2_o and len_o are stable while ins_vld_o = 1 and ins_rdy_i = 0.
REQ-025 Leaving HOLD on consume: with a simultaneous byte transfer, that byte is treated as the next byte0 (REQ-021); otherwise the FSM goes to IDLE.
REQ-026 Latency: ins_vld_o rises on the edge that transfers the final byte; there are no bubbles between consecutive instructions.
REQ-027 flush has priority over all transfers:
  - FSM returns to IDLE, k = 0, ins_vld_o = 0;
  - held fields are cleared to 0;
  - any byte presented that cycle is dropped.
REQ-028 data_i is ignored whenever data_vld_i = 0; the outputs do not change in that case.

Reset
REQ-029 While rst = 0, the block is in IDLE with k = 0, and ins_o, ad1_o, ad2_o, len_o, ins_vld_o and err_o are all 0; data_rdy_o = 1 after release.
REQ-030 A reset asserted mid-instruction discards all partial state; the first transfer after release is treated as byte0.

Verification
REQ-031 Defaults, LEN_TABLE entry(op 5) = 2; feed 0xA3, 0x11, 0x22 -> ins_vld_o on the 3rd edge with ins_o = 5, ad1_o = 3, ad2_o = 0x2211, len_o = 2.
REQ-032 Entry(op 1) = 0; feed 0x21 then 0x27 with ins_rdy_i = 1 held -> two consecutive valid cycles (ad1_o = 1, then 7), no idle cycle between them.
REQ-033 Hold instruction with ins_rdy_i = 0 for 4 cycles while data_vld_i = 1 -> data_rdy_o = 0, outputs stable; raise ins_rdy_i -> consume and next byte0 accepted on the same edge.
REQ-034 Entry(op 6) = 3 with MAXB = 3; feed 0xC0 -> err_o pulses 1 cycle, then ins_vld_o = 1 with len_o = 0.
REQ-035 Assert flush after operand byte 1 of a 3-byte instruction -> IDLE, ins_vld_o = 0; next byte 0x40 is decoded as opcode 2.
REQ-036 Assert rst low in OPND, release it, feed 0x00 with entry(op 0) = 0 -> held instruction is all-zero with ins_vld_o = 1 after one transfer.
